// File: rtl/maze_pkg.sv
// Shared maze definitions: cell-code constants, class bit positions and the
// map scanner state encoding.
package maze_pkg;

  localparam int unsigned CELL_IDX_W = 7;
  localparam int unsigned CODE_W     = 7;

  localparam logic [CODE_W-1:0] CODE_START = 7'h3F;
  localparam logic [CODE_W-1:0] CODE_GOAL  = 7'h00;
  localparam int unsigned       WALL_BIT   = 6;
  localparam logic [1:0]        MARK_FIELD = 2'b10;

  // Bit positions inside the one-hot class vector {start, goal, wall, mark, free}
  localparam int unsigned CLS_START = 4;
  localparam int unsigned CLS_GOAL  = 3;
  localparam int unsigned CLS_WALL  = 2;
  localparam int unsigned CLS_MARK  = 1;
  localparam int unsigned CLS_FREE  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/cell_classify.sv
// Combinational cell classifier: 7-bit cell code to one-hot
// {start, goal, wall, mark, free}, highest priority first.
module cell_classify
  import maze_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [4:0]        cls
);

  always_comb begin
    cls = '0;
    if (code == CODE_START) begin
      cls[CLS_START] = 1'b1;
    end else if (code == CODE_GOAL) begin
      cls[CLS_GOAL] = 1'b1;
    end else if (code[WALL_BIT]) begin
      cls[CLS_WALL] = 1'b1;
    end else if (code[5:4] == MARK_FIELD) begin
      cls[CLS_MARK] = 1'b1;
    end else begin
      cls[CLS_FREE] = 1'b1;
    end
  end

endmodule

// File: rtl/map_scan.sv
// Map RAM scanner: reads every cell in order, streams it downstream and
// latches start/goal positions and wall count for the path search.
module map_scan
  import maze_pkg::*;
#(
  parameter int unsigned CELLS = 128
) (
  input  logic                  m_clock,
  input  logic                  p_reset,
  input  logic                  scan_req,
  input  logic                  abort,
  output logic [CELL_IDX_W-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [CODE_W-1:0]     ram_data,
  output logic                  cell_valid,
  output logic [CODE_W-1:0]     cell_code,
  output logic [CELL_IDX_W-1:0] cell_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  start_found,
  output logic                  goal_found,
  output logic [CELL_IDX_W-1:0] start_pos,
  output logic [CELL_IDX_W-1:0] goal_pos,
  output logic [7:0]            wall_count,
  output logic                  err_multi
);

  localparam logic [CELL_IDX_W-1:0] LAST_ADDR = CELL_IDX_W'(CELLS - 1);

  scan_state_t state, next_state;
  logic        start_scan;
  logic        kill;
  logic [4:0]  cls;
  logic        unused_cls;

  assign start_scan = (state == ST_IDLE) && scan_req;
  assign kill       = abort && ((state == ST_SCAN) || (state == ST_DRAIN));

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (scan_req) next_state = ST_SCAN;
      ST_SCAN: begin
        if (abort)                      next_state = ST_IDLE;
        else if (ram_addr == LAST_ADDR) next_state = ST_DRAIN;
      end
      ST_DRAIN: next_state = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign ram_rd = (state == ST_SCAN);
  assign busy   = (state == ST_SCAN) || (state == ST_DRAIN);
  assign done   = (state == ST_DONE);

  // Address parks on the last cell once reached and holds until the next scan.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      ram_addr <= '0;
    end else if (start_scan) begin
      ram_addr <= '0;
    end else if ((state == ST_SCAN) && (ram_addr != LAST_ADDR)) begin
      ram_addr <= ram_addr + 1'b1;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      cell_valid <= 1'b0;
      cell_idx   <= '0;
    end else if (kill) begin
      cell_valid <= 1'b0;
      cell_idx   <= '0;
    end else begin
      cell_valid <= ram_rd;
      cell_idx   <= ram_addr;
    end
  end

  // RAM output is already registered; gate it so idle cycles present zero.
  assign cell_code = cell_valid ? ram_data : '0;

  cell_classify u_classify (
    .code (cell_code),
    .cls  (cls)
  );

  assign unused_cls = ^{cls[CLS_MARK], cls[CLS_FREE]};

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      start_found <= 1'b0;
      goal_found  <= 1'b0;
      start_pos   <= '0;
      goal_pos    <= '0;
      wall_count  <= '0;
      err_multi   <= 1'b0;
    end else if (start_scan || kill) begin
      start_found <= 1'b0;
      goal_found  <= 1'b0;
      start_pos   <= '0;
      goal_pos    <= '0;
      wall_count  <= '0;
      err_multi   <= 1'b0;
    end else if (cell_valid) begin
      if (cls[CLS_START]) begin
        if (start_found) begin
          err_multi <= 1'b1;
        end else begin
          start_found <= 1'b1;
          start_pos   <= cell_idx;
        end
      end
      if (cls[CLS_GOAL]) begin
        if (goal_found) begin
          err_multi <= 1'b1;
        end else begin
          goal_found <= 1'b1;
          goal_pos   <= cell_idx;
        end
      end
      if (cls[CLS_WALL]) wall_count <= wall_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_map_scan.sv
// Self-checking bench for map_scan: 128-cell scans against a behavioural
// model of the map, plus a single-cell instance for the CELLS=1 edge case.
module tb_map_scan;
  import maze_pkg::*;

  localparam int unsigned N = 128;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b0;
  logic       scan_req = 1'b0, abort = 1'b0;
  logic [6:0] ram_addr, ram_data = '0, cell_code, cell_idx, start_pos, goal_pos;
  logic       ram_rd, cell_valid, busy, done, start_found, goal_found, err_multi;
  logic [7:0] wall_count;

  logic       scan_req_1 = 1'b0, abort_1 = 1'b0;
  logic [6:0] ram_addr_1, ram_data_1 = '0, cell_code_1, cell_idx_1, start_pos_1, goal_pos_1;
  logic       ram_rd_1, cell_valid_1, busy_1, done_1, start_found_1, goal_found_1, err_multi_1;
  logic [7:0] wall_count_1;

  logic [6:0] mem [N];
  logic [6:0] mem1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 m_clock = ~m_clock;

  map_scan #(.CELLS(N)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .scan_req(scan_req), .abort(abort),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_data(ram_data),
    .cell_valid(cell_valid), .cell_code(cell_code), .cell_idx(cell_idx),
    .busy(busy), .done(done), .start_found(start_found), .goal_found(goal_found),
    .start_pos(start_pos), .goal_pos(goal_pos), .wall_count(wall_count), .err_multi(err_multi)
  );

  map_scan #(.CELLS(1)) dut1 (
    .m_clock(m_clock), .p_reset(p_reset), .scan_req(scan_req_1), .abort(abort_1),
    .ram_addr(ram_addr_1), .ram_rd(ram_rd_1), .ram_data(ram_data_1),
    .cell_valid(cell_valid_1), .cell_code(cell_code_1), .cell_idx(cell_idx_1),
    .busy(busy_1), .done(done_1), .start_found(start_found_1), .goal_found(goal_found_1),
    .start_pos(start_pos_1), .goal_pos(goal_pos_1), .wall_count(wall_count_1), .err_multi(err_multi_1)
  );

  // Map RAM models: data appears one cycle after the read strobe.
  always @(posedge m_clock) if (ram_rd) ram_data <= mem[ram_addr];
  always @(posedge m_clock) if (ram_rd_1) ram_data_1 <= mem1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_results_zero(input string pfx);
    check({pfx, "_start_found"}, 32'(start_found), 0);
    check({pfx, "_goal_found"}, 32'(goal_found), 0);
    check({pfx, "_start_pos"}, 32'(start_pos), 0);
    check({pfx, "_goal_pos"}, 32'(goal_pos), 0);
    check({pfx, "_wall_count"}, 32'(wall_count), 0);
    check({pfx, "_err_multi"}, 32'(err_multi), 0);
  endtask

  task automatic fill_free();
    logic [6:0] v;
    for (int i = 0; i < N; i++) begin
      v = 7'($urandom_range(1, 62));
      mem[i] = v;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 7'($urandom);
  endtask

  // One scan of the 128-cell instance. abort_at/req_at/reset_at name the
  // cycle (numbered from the scan_req edge) where the disturbance is applied;
  // 0 means none.
  task automatic run_scan(input string name, input int abort_at, input int req_at, input int reset_at);
    bit sf = 0, gf = 0, em = 0;
    int sp = 0, gp = 0, wc = 0;
    int dones = 0;
    bit killed = 0;
    for (int i = 0; i < N; i++) begin
      if (mem[i] == 7'h3F) begin
        if (sf) em = 1; else begin sf = 1; sp = i; end
      end else if (mem[i] == 7'h00) begin
        if (gf) em = 1; else begin gf = 1; gp = i; end
      end else if (mem[i] >= 7'h40) begin
        wc++;
      end
    end

    @(negedge m_clock); scan_req = 1'b1;
    @(negedge m_clock);
    for (int c = 1; c <= int'(N) + 4; c++) begin
      if (c > 1) @(negedge m_clock);
      scan_req = 1'b0;
      abort    = 1'b0;
      if (c == reset_at) begin
        p_reset = 1'b0;
        #1;
        check({name, "_rst_busy"}, 32'(busy), 0);
        check({name, "_rst_ram_rd"}, 32'(ram_rd), 0);
        check({name, "_rst_ram_addr"}, 32'(ram_addr), 0);
        check({name, "_rst_valid"}, 32'(cell_valid), 0);
        check({name, "_rst_code"}, 32'(cell_code), 0);
        check({name, "_rst_idx"}, 32'(cell_idx), 0);
        check({name, "_rst_done"}, 32'(done), 0);
        check_results_zero({name, "_rst"});
        #1 p_reset = 1'b1;
        @(negedge m_clock);
        check({name, "_rst_idle_busy"}, 32'(busy), 0);
        check({name, "_rst_idle_rd"}, 32'(ram_rd), 0);
        return;
      end
      dones += int'(done);
      if (killed) begin
        check({name, "_abort_busy"}, 32'(busy), 0);
        check({name, "_abort_valid"}, 32'(cell_valid), 0);
        check({name, "_abort_done"}, 32'(done), 0);
        if (c == abort_at + 1) check_results_zero({name, "_abort"});
      end else begin
        check({name, "_busy"}, 32'(busy), 32'(c <= int'(N) + 1));
        check({name, "_ram_rd"}, 32'(ram_rd), 32'(c <= int'(N)));
        if (c <= int'(N)) check({name, "_ram_addr"}, 32'(ram_addr), 32'(c - 1));
        else              check({name, "_ram_addr_hold"}, 32'(ram_addr), N - 1);
        check({name, "_valid"}, 32'(cell_valid), 32'(c >= 2 && c <= int'(N) + 1));
        if (c >= 2 && c <= int'(N) + 1) begin
          check({name, "_idx"}, 32'(cell_idx), 32'(c - 2));
          check({name, "_code"}, 32'(cell_code), 32'(mem[c-2]));
        end
        check({name, "_done"}, 32'(done), 32'(c == int'(N) + 2));
        if (c == int'(N) + 2 || c == int'(N) + 4) begin
          check({name, "_start_found"}, 32'(start_found), 32'(sf));
          check({name, "_goal_found"}, 32'(goal_found), 32'(gf));
          check({name, "_start_pos"}, 32'(start_pos), 32'(sp));
          check({name, "_goal_pos"}, 32'(goal_pos), 32'(gp));
          check({name, "_wall_count"}, 32'(wall_count), 32'(wc));
          check({name, "_err_multi"}, 32'(err_multi), 32'(em));
        end
      end
      if (c == abort_at) begin abort = 1'b1; killed = 1; end
      if (c == req_at) scan_req = 1'b1;
    end
    check({name, "_done_pulses"}, 32'(dones), 32'(killed ? 0 : 1));
  endtask

  task automatic plan_a();
    for (int i = 0; i < N; i++) mem[i] = 7'h21;
    mem[5] = 7'h3F;
    mem[100] = 7'h00;
    for (int i = 10; i <= 19; i++) mem[i] = 7'h40;
  endtask

  initial begin
    logic [6:0] codes1 [4];
    codes1[0] = 7'h00; codes1[1] = 7'h40; codes1[2] = 7'h3F; codes1[3] = 7'h21;

    repeat (3) @(negedge m_clock);
    check("reset_busy", 32'(busy), 0);
    check("reset_ram_addr", 32'(ram_addr), 0);
    check("reset_valid", 32'(cell_valid), 0);
    check("reset_done", 32'(done), 0);
    check_results_zero("reset");
    check("reset1_busy", 32'(busy_1), 0);
    check("reset1_done", 32'(done_1), 0);
    p_reset = 1'b1;
    @(negedge m_clock);

    plan_a();
    run_scan("planA", 0, 0, 0);

    for (int i = 0; i < N; i++) mem[i] = 7'h21;
    mem[3] = 7'h3F; mem[40] = 7'h3F; mem[7] = 7'h00;
    run_scan("multi", 0, 0, 0);

    fill_free();
    run_scan("free", 0, 0, 0);

    plan_a();
    run_scan("abort", 50, 0, 0);
    run_scan("after_abort", 0, 0, 0);

    fill_random();
    run_scan("midreq", 0, 20, 0);

    plan_a();
    run_scan("midreset", 0, 0, 30);
    run_scan("after_reset", 0, 0, 0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_scan("rand", 0, 0, 0);
    end

    // Single-cell instance: cell_valid in cycle 2, done in cycle 3.
    for (int t = 0; t < 4; t++) begin
      mem1 = codes1[t];
      @(negedge m_clock); scan_req_1 = 1'b1;
      @(negedge m_clock); scan_req_1 = 1'b0;
      check("c1_busy1", 32'(busy_1), 1);
      check("c1_rd1", 32'(ram_rd_1), 1);
      check("c1_addr1", 32'(ram_addr_1), 0);
      check("c1_valid1", 32'(cell_valid_1), 0);
      @(negedge m_clock);
      check("c1_rd2", 32'(ram_rd_1), 0);
      check("c1_busy2", 32'(busy_1), 1);
      check("c1_valid2", 32'(cell_valid_1), 1);
      check("c1_idx2", 32'(cell_idx_1), 0);
      check("c1_code2", 32'(cell_code_1), 32'(mem1));
      check("c1_done2", 32'(done_1), 0);
      @(negedge m_clock);
      check("c1_done3", 32'(done_1), 1);
      check("c1_busy3", 32'(busy_1), 0);
      check("c1_goal_found", 32'(goal_found_1), 32'(mem1 == 7'h00));
      check("c1_start_found", 32'(start_found_1), 32'(mem1 == 7'h3F));
      check("c1_goal_pos", 32'(goal_pos_1), 0);
      check("c1_wall_count", 32'(wall_count_1), 32'(mem1 >= 7'h40));
      check("c1_err_multi", 32'(err_multi_1), 0);
      @(negedge m_clock);
      check("c1_done4", 32'(done_1), 0);
      check("c1_addr_hold", 32'(ram_addr_1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
